// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared types and constants for the RV32I queued decode stage.
//   op_e   : 7-bit operation code. The M-extension codes are always reserved so
//            the numbering is identical whether or not DEC_RV32M_EN is defined.
//   CLS_*  : bit positions inside the one-hot class vector
//            {store,load,branch,jump,reg,imm,upper}.
//   OPC_* / F3_* / F7_* : major opcode, funct3 and funct7 encodings.
//   fmt_e  : immediate format selector used by imm_gen().
//   dec_s  : complete decode result for one instruction.
// Optional feature macro: DEC_RV32M_EN (consumed by dec_core).
// -----------------------------------------------------------------------------
package dec_pkg;

  typedef enum logic [6:0] {
    OP_ILLEGAL = 7'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND,
    OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK,
    OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  // Class vector bit positions.
  localparam int CLS_UPPER  = 0;
  localparam int CLS_IMM    = 1;
  localparam int CLS_REG    = 2;
  localparam int CLS_JUMP   = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_LOAD   = 5;
  localparam int CLS_STORE  = 6;

  // Major opcodes.
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // funct3: ALU (OP / OP-IMM).
  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100, F3_SR  = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111;
  // funct3: branches.
  localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;
  // funct3: load/store widths.
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  // funct3: MISC-MEM and SYSTEM.
  localparam logic [2:0] F3_FENCE = 3'b000, F3_FENCE_I = 3'b001, F3_PRIV = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001, F3_CSRRS  = 3'b010, F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101, F3_CSRRSI = 3'b110, F3_CSRRCI = 3'b111;
  // funct3: M extension.
  localparam logic [2:0] F3_MUL = 3'b000, F3_MULH = 3'b001, F3_MULHSU = 3'b010, F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIV = 3'b100, F3_DIVU = 3'b101, F3_REM    = 3'b110, F3_REMU  = 3'b111;

  // funct7.
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef struct packed {
    op_e         op;
    logic [6:0]  cls;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } dec_s;

  // Immediate reassembly; B and J drop bit 0, U is left-aligned.
  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input fmt_e fmt);
    case (fmt)
      FMT_I:   return {{20{inst[31]}}, inst[31:20]};
      FMT_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   return {inst[31:12], 12'b0};
      FMT_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dec_core.sv
// -----------------------------------------------------------------------------
// dec_core
// Purely combinational RV32I decoder (plus FENCE/FENCE.I/ECALL/EBREAK/CSR).
// Ports:
//   i_inst [31:0] : instruction word
//   o_dec  dec_s  : decoded op, class, register fields, immediate, illegal flag
// Optional feature macro: DEC_RV32M_EN -- when defined, the eight RV32M ops are
// recognised; otherwise their encodings decode as illegal.
// -----------------------------------------------------------------------------
module dec_core
  import dec_pkg::*;
(
  input  logic [31:0] i_inst,
  output dec_s        o_dec
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  op_e        w_op;
  fmt_e       w_fmt;
  logic [6:0] w_cls;

  assign w_opc = i_inst[6:0];
  assign w_f3  = i_inst[14:12];
  assign w_f7  = i_inst[31:25];

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    w_op  = OP_ILLEGAL;
    w_fmt = FMT_R;
    w_cls = '0;
    case (w_opc)
      OPC_LUI:   begin w_op = OP_LUI;   w_fmt = FMT_U; w_cls[CLS_UPPER] = 1'b1; end
      OPC_AUIPC: begin w_op = OP_AUIPC; w_fmt = FMT_U; w_cls[CLS_UPPER] = 1'b1; end
      OPC_JAL:   begin w_op = OP_JAL;   w_fmt = FMT_J; w_cls[CLS_JUMP]  = 1'b1; end
      OPC_JALR: begin
        w_fmt = FMT_I; w_cls[CLS_JUMP] = 1'b1;
        if (w_f3 == 3'b000) w_op = OP_JALR;
      end
      OPC_BRANCH: begin
        w_fmt = FMT_B; w_cls[CLS_BRANCH] = 1'b1;
        case (w_f3)
          F3_BEQ:  w_op = OP_BEQ;
          F3_BNE:  w_op = OP_BNE;
          F3_BLT:  w_op = OP_BLT;
          F3_BGE:  w_op = OP_BGE;
          F3_BLTU: w_op = OP_BLTU;
          F3_BGEU: w_op = OP_BGEU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        w_fmt = FMT_I; w_cls[CLS_LOAD] = 1'b1;
        case (w_f3)
          F3_B:    w_op = OP_LB;
          F3_H:    w_op = OP_LH;
          F3_W:    w_op = OP_LW;
          F3_BU:   w_op = OP_LBU;
          F3_HU:   w_op = OP_LHU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        w_fmt = FMT_S; w_cls[CLS_STORE] = 1'b1;
        case (w_f3)
          F3_B:    w_op = OP_SB;
          F3_H:    w_op = OP_SH;
          F3_W:    w_op = OP_SW;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_OP_IMM: begin
        w_fmt = FMT_I; w_cls[CLS_IMM] = 1'b1;
        case (w_f3)
          F3_ADD:  w_op = OP_ADDI;
          F3_SLT:  w_op = OP_SLTI;
          F3_SLTU: w_op = OP_SLTIU;
          F3_XOR:  w_op = OP_XORI;
          F3_OR:   w_op = OP_ORI;
          F3_AND:  w_op = OP_ANDI;
          // Shift-immediates carry funct7 in imm[11:5]; only the two legal
          // patterns are accepted.
          F3_SLL:  w_op = (w_f7 == F7_BASE) ? OP_SLLI : OP_ILLEGAL;
          F3_SR:   w_op = (w_f7 == F7_BASE) ? OP_SRLI :
                          (w_f7 == F7_ALT)  ? OP_SRAI : OP_ILLEGAL;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_OP: begin
        w_fmt = FMT_R; w_cls[CLS_REG] = 1'b1;
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            F3_ADD:  w_op = OP_ADD;
            F3_SLL:  w_op = OP_SLL;
            F3_SLT:  w_op = OP_SLT;
            F3_SLTU: w_op = OP_SLTU;
            F3_XOR:  w_op = OP_XOR;
            F3_SR:   w_op = OP_SRL;
            F3_OR:   w_op = OP_OR;
            default: w_op = OP_AND;
          endcase
        end else if (w_f7 == F7_ALT) begin
          case (w_f3)
            F3_ADD:  w_op = OP_SUB;
            F3_SR:   w_op = OP_SRA;
            default: w_op = OP_ILLEGAL;
          endcase
        end
`ifdef DEC_RV32M_EN
        else if (w_f7 == F7_MULDIV) begin
          case (w_f3)
            F3_MUL:    w_op = OP_MUL;
            F3_MULH:   w_op = OP_MULH;
            F3_MULHSU: w_op = OP_MULHSU;
            F3_MULHU:  w_op = OP_MULHU;
            F3_DIV:    w_op = OP_DIV;
            F3_DIVU:   w_op = OP_DIVU;
            F3_REM:    w_op = OP_REM;
            default:   w_op = OP_REMU;
          endcase
        end
`endif
      end
      OPC_MISC_MEM: begin
        w_fmt = FMT_I; w_cls[CLS_IMM] = 1'b1;
        case (w_f3)
          F3_FENCE:   w_op = OP_FENCE;
          F3_FENCE_I: w_op = OP_FENCE_I;
          default:    w_op = OP_ILLEGAL;
        endcase
      end
      OPC_SYSTEM: begin
        w_fmt = FMT_I; w_cls[CLS_IMM] = 1'b1;
        case (w_f3)
          // ECALL/EBREAK are recognised only as their exact full words.
          F3_PRIV:   w_op = (i_inst[31:7] == 25'h0)             ? OP_ECALL  :
                            (i_inst[31:7] == {12'h001, 13'h0})  ? OP_EBREAK : OP_ILLEGAL;
          F3_CSRRW:  w_op = OP_CSRRW;
          F3_CSRRS:  w_op = OP_CSRRS;
          F3_CSRRC:  w_op = OP_CSRRC;
          F3_CSRRWI: w_op = OP_CSRRWI;
          F3_CSRRSI: w_op = OP_CSRRSI;
          F3_CSRRCI: w_op = OP_CSRRCI;
          default:   w_op = OP_ILLEGAL;
        endcase
      end
      default: w_op = OP_ILLEGAL;
    endcase

    o_dec.op      = w_op;
    o_dec.rs1     = i_inst[19:15];
    o_dec.rs2     = i_inst[24:20];
    o_dec.rd      = i_inst[11:7];
    o_dec.illegal = (w_op == OP_ILLEGAL);
    // An unrecognised word has no class and no meaningful immediate.
    o_dec.cls     = o_dec.illegal ? 7'b0  : w_cls;
    o_dec.imm     = o_dec.illegal ? 32'b0 : imm_gen(i_inst, w_fmt);
  end

endmodule

// File: rtl/dec_stage_q.sv
// -----------------------------------------------------------------------------
// dec_stage_q
// Queued decode stage between IFU and EXU: a DEPTH-entry instruction FIFO, a
// combinational decoder on the FIFO head, and a registered output slot.
// Total buffering is DEPTH+1 instructions.
// Parameters: DEPTH (power of two, 2..16), PC_W (PC sideband width).
// Ports:
//   hclk, hrstn           : clock, asynchronous active-low reset
//   flush                 : discard queue and output slot (beats push/pop)
//   in_valid/in_ready     : IFU handshake, in_inst/in_pc payload
//   out_valid/out_ready   : EXU handshake, out_inst/out_pc raw payload
//   dec_op/dec_class/dec_rs1/dec_rs2/dec_rd/dec_imm/dec_illegal : decode result
//   q_count               : queue occupancy (output slot not included)
// Optional feature macro: DEC_RV32M_EN (RV32M decode inside dec_core).
// -----------------------------------------------------------------------------
module dec_stage_q
  import dec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     hclk,
  input  logic                     hrstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [PC_W-1:0]          out_pc,
  output op_e                      dec_op,
  output logic [6:0]               dec_class,
  output logic [4:0]               dec_rs1,
  output logic [4:0]               dec_rs2,
  output logic [4:0]               dec_rd,
  output logic [31:0]              dec_imm,
  output logic                     dec_illegal,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     r_mem_inst [DEPTH];
  logic [PC_W-1:0] r_mem_pc   [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            r_out_valid;
  logic [31:0]     r_out_inst;
  logic [PC_W-1:0] r_out_pc;
  dec_s            r_dec;

  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_head_inst;
  dec_s            w_head_dec;

  // Ready looks only at occupancy (never at a same-cycle pop) and is held high
  // during flush; it is forced low while the block is held in reset.
  assign in_ready = hrstn && (flush || (r_count < CW'(DEPTH)));
  assign w_push   = in_valid && in_ready && !flush;
  // The head moves into the slot when the slot is free or being drained.
  assign w_pop    = !flush && (r_count != '0) && (!r_out_valid || out_ready);

  assign w_head_inst = r_mem_inst[r_rd_ptr];

  dec_core u_dec_core (
    .i_inst (w_head_inst),
    .o_dec  (w_head_dec)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge hclk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= in_inst;
      r_mem_pc[r_wr_ptr]   <= in_pc;
    end
  end

  // Output slot. Payload only changes on a load, so it holds during a stall
  // and keeps its last value after draining or flushing.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_pc    <= '0;
      r_dec       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_inst  <= w_head_inst;
      r_out_pc    <= r_mem_pc[r_rd_ptr];
      r_dec       <= w_head_dec;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_inst    = r_out_inst;
  assign out_pc      = r_out_pc;
  assign dec_op      = r_dec.op;
  assign dec_class   = r_dec.cls;
  assign dec_rs1     = r_dec.rs1;
  assign dec_rs2     = r_dec.rs2;
  assign dec_rd      = r_dec.rd;
  assign dec_imm     = r_dec.imm;
  assign dec_illegal = r_dec.illegal;
  assign q_count     = r_count;

endmodule

// File: tb/tb_dec_stage_q.sv
// -----------------------------------------------------------------------------
// tb_dec_stage_q
// Scoreboard bench for dec_stage_q. Accepted pushes are decoded by a table-driven
// reference model (mask/match rules) and queued; a monitor pops and compares on
// every output transfer. Directed sections cover reset, latency, full/stall,
// flush and asynchronous reset. Honors DEC_RV32M_EN like the design.
// -----------------------------------------------------------------------------
module tb_dec_stage_q;
  import dec_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  localparam int F_R = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5;
  localparam logic [6:0] C_ST = 7'h40, C_LD = 7'h20, C_BR = 7'h10, C_JP = 7'h08;
  localparam logic [6:0] C_RG = 7'h04, C_IM = 7'h02, C_UP = 7'h01;
  localparam logic [31:0] M_OP = 32'h0000007F, M_F3 = 32'h0000707F;
  localparam logic [31:0] M_F7 = 32'hFE00707F, M_ALL = 32'hFFFFFFFF;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    op_e         op;
    logic [6:0]  cls;
    int          fmt;
  } rule_t;

  typedef struct {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    op_e             op;
    logic [6:0]      cls;
    logic [31:0]     imm;
    logic            ill;
  } exp_t;

  logic                  hclk = 1'b0, hrstn = 1'b1, flush = 1'b0;
  logic                  in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]           in_inst = '0;
  logic [PC_W-1:0]       in_pc = '0;
  logic                  in_ready, out_valid, dec_illegal;
  logic [31:0]           out_inst, dec_imm;
  logic [PC_W-1:0]       out_pc;
  op_e                   dec_op;
  logic [6:0]            dec_class;
  logic [4:0]            dec_rs1, dec_rs2, dec_rd;
  logic [$clog2(DEPTH):0] q_count;

  rule_t rules[$];
  exp_t  sb[$];
  int    n_vec = 0, n_err = 0, n_push = 0;

  dec_stage_q #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .hclk(hclk), .hrstn(hrstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .dec_op(dec_op), .dec_class(dec_class), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_imm(dec_imm), .dec_illegal(dec_illegal), .q_count(q_count)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] enc(input int f7, input int f3, input int opc);
    return 32'((f7 << 25) | (f3 << 12) | opc);
  endfunction

  task automatic add(input logic [31:0] m, input logic [31:0] mt, input op_e op,
                     input logic [6:0] c, input int f);
    rule_t r;
    r.mask = m; r.match = mt; r.op = op; r.cls = c; r.fmt = f;
    rules.push_back(r);
  endtask

  task automatic build_rules();
    add(M_OP, enc(0,0,'h37), OP_LUI,   C_UP, F_U); add(M_OP, enc(0,0,'h17), OP_AUIPC, C_UP, F_U);
    add(M_OP, enc(0,0,'h6F), OP_JAL,   C_JP, F_J); add(M_F3, enc(0,0,'h67), OP_JALR,  C_JP, F_I);
    add(M_F3, enc(0,0,'h63), OP_BEQ,  C_BR, F_B); add(M_F3, enc(0,1,'h63), OP_BNE,  C_BR, F_B);
    add(M_F3, enc(0,4,'h63), OP_BLT,  C_BR, F_B); add(M_F3, enc(0,5,'h63), OP_BGE,  C_BR, F_B);
    add(M_F3, enc(0,6,'h63), OP_BLTU, C_BR, F_B); add(M_F3, enc(0,7,'h63), OP_BGEU, C_BR, F_B);
    add(M_F3, enc(0,0,'h03), OP_LB,  C_LD, F_I); add(M_F3, enc(0,1,'h03), OP_LH,  C_LD, F_I);
    add(M_F3, enc(0,2,'h03), OP_LW,  C_LD, F_I); add(M_F3, enc(0,4,'h03), OP_LBU, C_LD, F_I);
    add(M_F3, enc(0,5,'h03), OP_LHU, C_LD, F_I);
    add(M_F3, enc(0,0,'h23), OP_SB, C_ST, F_S); add(M_F3, enc(0,1,'h23), OP_SH, C_ST, F_S);
    add(M_F3, enc(0,2,'h23), OP_SW, C_ST, F_S);
    add(M_F3, enc(0,0,'h13), OP_ADDI, C_IM, F_I); add(M_F3, enc(0,2,'h13), OP_SLTI,  C_IM, F_I);
    add(M_F3, enc(0,3,'h13), OP_SLTIU, C_IM, F_I); add(M_F3, enc(0,4,'h13), OP_XORI, C_IM, F_I);
    add(M_F3, enc(0,6,'h13), OP_ORI,  C_IM, F_I); add(M_F3, enc(0,7,'h13), OP_ANDI,  C_IM, F_I);
    add(M_F7, enc(0,1,'h13), OP_SLLI, C_IM, F_I); add(M_F7, enc(0,5,'h13), OP_SRLI,  C_IM, F_I);
    add(M_F7, enc('h20,5,'h13), OP_SRAI, C_IM, F_I);
    add(M_F7, enc(0,0,'h33), OP_ADD, C_RG, F_R); add(M_F7, enc(0,1,'h33), OP_SLL,  C_RG, F_R);
    add(M_F7, enc(0,2,'h33), OP_SLT, C_RG, F_R); add(M_F7, enc(0,3,'h33), OP_SLTU, C_RG, F_R);
    add(M_F7, enc(0,4,'h33), OP_XOR, C_RG, F_R); add(M_F7, enc(0,5,'h33), OP_SRL,  C_RG, F_R);
    add(M_F7, enc(0,6,'h33), OP_OR,  C_RG, F_R); add(M_F7, enc(0,7,'h33), OP_AND,  C_RG, F_R);
    add(M_F7, enc('h20,0,'h33), OP_SUB, C_RG, F_R); add(M_F7, enc('h20,5,'h33), OP_SRA, C_RG, F_R);
    add(M_F3, enc(0,0,'h0F), OP_FENCE, C_IM, F_I); add(M_F3, enc(0,1,'h0F), OP_FENCE_I, C_IM, F_I);
    add(M_ALL, 32'h00000073, OP_ECALL, C_IM, F_I); add(M_ALL, 32'h00100073, OP_EBREAK, C_IM, F_I);
    add(M_F3, enc(0,1,'h73), OP_CSRRW,  C_IM, F_I); add(M_F3, enc(0,2,'h73), OP_CSRRS,  C_IM, F_I);
    add(M_F3, enc(0,3,'h73), OP_CSRRC,  C_IM, F_I); add(M_F3, enc(0,5,'h73), OP_CSRRWI, C_IM, F_I);
    add(M_F3, enc(0,6,'h73), OP_CSRRSI, C_IM, F_I); add(M_F3, enc(0,7,'h73), OP_CSRRCI, C_IM, F_I);
`ifdef DEC_RV32M_EN
    add(M_F7, enc(1,0,'h33), OP_MUL,  C_RG, F_R); add(M_F7, enc(1,1,'h33), OP_MULH,   C_RG, F_R);
    add(M_F7, enc(1,2,'h33), OP_MULHSU, C_RG, F_R); add(M_F7, enc(1,3,'h33), OP_MULHU, C_RG, F_R);
    add(M_F7, enc(1,4,'h33), OP_DIV,  C_RG, F_R); add(M_F7, enc(1,5,'h33), OP_DIVU,   C_RG, F_R);
    add(M_F7, enc(1,6,'h33), OP_REM,  C_RG, F_R); add(M_F7, enc(1,7,'h33), OP_REMU,   C_RG, F_R);
`endif
  endtask

  // Immediates built arithmetically from the field layout of each format.
  function automatic logic [31:0] ref_imm(input logic [31:0] w, input int fmt);
    int s;
    s = $signed(w);
    case (fmt)
      F_I: return 32'(s >>> 20);
      F_S: return 32'((s >>> 25) << 5) | ((w >> 7) & 32'h1F);
      F_B: return 32'((s >>> 31) << 12) | (((w >> 7) & 32'h1) << 11) |
                  (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
      F_U: return w & 32'hFFFFF000;
      F_J: return 32'((s >>> 31) << 20) | (w & 32'h000FF000) |
                  (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] w, input logic [PC_W-1:0] pc);
    exp_t e;
    e.inst = w; e.pc = pc; e.op = OP_ILLEGAL; e.cls = '0; e.imm = '0; e.ill = 1'b1;
    foreach (rules[i]) begin
      if ((w & rules[i].mask) == rules[i].match) begin
        e.op = rules[i].op; e.cls = rules[i].cls;
        e.imm = ref_imm(w, rules[i].fmt); e.ill = 1'b0;
      end
    end
    return e;
  endfunction

  // Mostly legal words drawn from the rule table, plus fully random words.
  function automatic logic [31:0] gen();
    int k;
    if ($urandom_range(0, 4) == 0) return $urandom;
    k = $urandom_range(0, rules.size() - 1);
    return ($urandom & ~rules[k].mask) | rules[k].match;
  endfunction

  // ---------------- scoreboard processes ----------------
  always @(negedge hclk) begin
    if (!hrstn || flush) sb.delete();
    else if (in_valid && in_ready) begin
      sb.push_back(ref_dec(in_inst, in_pc));
      n_push++;
    end
  end

  always @(negedge hclk) begin
    exp_t e;
    if (hrstn && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        check("out_inst", out_inst, e.inst);
        check("out_pc", out_pc, e.pc);
        check("dec_op", dec_op, e.op);
        check("dec_class", dec_class, e.cls);
        check("dec_imm", dec_imm, e.imm);
        check("dec_illegal", dec_illegal, e.ill);
        check("dec_regs", {dec_rs1, dec_rs2, dec_rd}, {e.inst[19:15], e.inst[24:20], e.inst[11:7]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge hclk); #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [PC_W-1:0] pc);
    in_inst = w; in_pc = pc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("latency_edge_n", out_valid, 0);
    tick();
  endtask

  initial begin
    logic [31:0] first_inst;
    build_rules();

    // Reset state.
    #1 hrstn = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_q_count", q_count, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_dec", {dec_op, dec_class, dec_imm, dec_illegal}, 0);
    tick(); tick();
    hrstn = 1'b1;
    #1 check("in_ready_after_rst", in_ready, 1);

    // ADDI x1,x2,-1 with two-edge latency, then drain.
    out_ready = 1'b1;
    send(32'hFFF10093, 32'h100);
    check("addi_valid", out_valid, 1);
    check("addi_op", dec_op, OP_ADDI);
    check("addi_class", dec_class, C_IM);
    check("addi_rd_rs1", {dec_rd, dec_rs1}, {5'd1, 5'd2});
    check("addi_imm", dec_imm, 32'hFFFFFFFF);
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_hold_op", dec_op, OP_ADDI);

    // JAL x0,-4.
    send(32'hFFDFF06F, 32'h104);
    check("jal_op", dec_op, OP_JAL);
    check("jal_class", dec_class, C_JP);
    check("jal_imm", dec_imm, 32'hFFFFFFFC);
    check("jal_rd", dec_rd, 0);
    tick();

    // All-zero word is illegal but still delivered.
    send(32'h00000000, 32'h108);
    check("zero_valid", out_valid, 1);
    check("zero_illegal", dec_illegal, 1);
    check("zero_op", dec_op, OP_ILLEGAL);
    check("zero_class", dec_class, 0);
    tick();

    // MUL x1,x2,x3.
    send(32'h023100B3, 32'h10C);
`ifdef DEC_RV32M_EN
    check("mul_op", dec_op, OP_MUL);
    check("mul_class", dec_class, C_RG);
    check("mul_rs2", dec_rs2, 3);
`else
    check("mul_illegal", dec_illegal, 1);
    check("mul_op", dec_op, OP_ILLEGAL);
`endif
    tick();

    // Fill with out_ready low: DEPTH+1 accepted, outputs frozen on the first.
    out_ready = 1'b0;
    n_push = 0;
    in_valid = 1'b1;
    first_inst = '0;
    for (int i = 0; i < 10; i++) begin
      in_inst = gen();
      in_pc = 32'h1000 + 32'(4 * i);
      if (i == 0) first_inst = in_inst;
      tick();
      if (i >= 1) begin
        check("stall_valid", out_valid, 1);
        check("stall_inst", out_inst, first_inst);
      end
    end
    in_valid = 1'b0;
    check("full_pushes", n_push, 5);
    check("full_count", q_count, 4);
    check("full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_stream_valid", out_valid, 1);
      tick();
    end
    check("drain_stream_end", out_valid, 0);

    // Flush with 3 queued + 1 in slot and a concurrent push.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_inst = gen(); in_pc = 32'h2000 + 32'(4 * i);
      tick();
    end
    check("preflush_count", q_count, 3);
    check("preflush_valid", out_valid, 1);
    flush = 1'b1; in_inst = 32'h00500093; in_pc = 32'h3000;
    #1 check("flush_in_ready", in_ready, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", q_count, 0);
    check("flush_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_no_reappear", out_valid, 0);
    end

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_inst   = gen();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) tick();
    check("sb_drained", 64'(sb.size()), 0);

    // Asynchronous reset with 2 queued and a full slot.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_inst = gen(); in_pc = 32'h4000 + 32'(4 * i);
      tick();
    end
    in_valid = 1'b0;
    check("prerst_count", q_count, 2);
    check("prerst_valid", out_valid, 1);
    @(negedge hclk);
    #2 hrstn = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_count", q_count, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_payload", {out_inst, out_pc}, 0);
    check("arst_dec", {dec_op, dec_class, dec_rs1, dec_rs2, dec_rd, dec_illegal}, 0);
    check("arst_imm", dec_imm, 0);
    sb.delete();
    tick();
    hrstn = 1'b1;
    tick();
    check("post_arst_in_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dec_stage_q.md
Name: dec_stage_q

Overview:
Parametrised successor to the single-cycle RV32I decoder. Buffers fetched instructions in a DEPTH-entry queue, decodes the head entry and presents the result in a registered output slot with valid/ready handshakes on both sides. It adds flush, illegal-instruction detection and queue-occupancy reporting. Sits between the IFU and the EXU.

Parameters:
DEPTH, 4, instruction queue entries; power of two, 2..16.
PC_W, 32, width of the program-counter sideband carried with each instruction.

Ports:
hclk  in  1  clock
hrstn  in  1  asynchronous active-low reset
flush  in  1  discard queue and output slot
in_valid  in  1  IFU offers an instruction
in_ready  out  1  queue can accept
in_inst  in  32  instruction word
in_pc  in  PC_W  instruction address
out_valid  out  1  decoded result valid
out_ready  in  1  EXU accepts result
out_inst  out  32  raw instruction
out_pc  out  PC_W  instruction address
dec_op  out  7  operation enum (dec_pkg::op_e)
dec_class  out  7  one-hot {store,load,branch,jump,reg,imm,upper}
dec_rs1  out  5  source register 1
dec_rs2  out  5  source register 2
dec_rd  out  5  destination register
dec_imm  out  32  immediate, sign-extended per format I/S/B/U/J, 0 for R-type
dec_illegal  out  1  unrecognised encoding
q_count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Clock/reset: one clock, hclk. Reset hrstn is asynchronous and active-low.
- Reset: all outputs are 0, including out_valid, q_count and dec_*. in_ready is 1 once hrstn is high. Queue pointers are cleared.
- Push: a push occurs when in_valid && in_ready at the rising edge.
  - in_ready = (q_count < DEPTH). It does not depend on a same-cycle pop.
- Output slot: the slot loads from the decoded queue head when the head is non-empty and (!out_valid || out_ready). This pops the head.
  - Latency: an instruction pushed at edge N appears with out_valid=1 after edge N+1, provided the queue was empty and the slot was free.
- Stall: while out_valid && !out_ready, every out_* and dec_* output holds stable.
- Drain: when the slot empties (out_ready=1) and the queue is empty, out_valid goes to 0 at the next edge. dec_* keep their last values.
- Simultaneous push and pop: q_count is unchanged, and the pointers wrap modulo DEPTH.
- Total capacity is DEPTH+1: DEPTH entries in the queue plus one in the output slot.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - At the next edge: q_count=0, out_valid=0, pointers cleared.
  - A same-cycle push is dropped.
  - in_ready stays 1 while flush is asserted.
- Decode:
  - Covers the full RV32I set plus FENCE, FENCE.I, ECALL, EBREAK and the six CSR ops.
  - Exact match on opcode, funct3 and funct7. funct7 is checked for SLLI/SRLI/SRAI and for R-type.
  - Any other encoding gives dec_op=OP_ILLEGAL, dec_illegal=1, dec_class=0. The entry is still delivered.
- Immediates:
  - I, S, B and J immediates are sign-extended from their top bit.
  - U immediate is {inst[31:12],12'b0}.
  - B and J immediates have bit 0 = 0.
- Register fields are taken verbatim from inst bits regardless of format.

Optional Feature:
DEC_RV32M_EN:
- Defined: decode MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (opcode 0110011, funct7 0000001) to their op_e values, with dec_class=reg.
- Undefined: these encodings are OP_ILLEGAL with dec_illegal=1.
- The op_e enum always reserves the M codes so the encoding is stable in both builds.

Decomposition:
- dec_pkg holds:
  - op_e enum, 7 bits;
  - class bit index constants;
  - opcode, funct3 and funct7 localparams;
  - a dec_s struct {op, class, rs1, rs2, rd, imm, illegal}.
- Sub-module dec_core: purely combinational, maps inst[31:0] to dec_s.
- dec_stage_q owns the queue, the output slot, flush and the handshakes.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093) pushed into an empty block, out_ready=1 → two edges later: out_valid=1, dec_op=OP_ADDI, dec_class=imm, rd=1, rs1=2, dec_imm=0xFFFFFFFF.
- JAL x0,-4 (0xFFDFF06F) → dec_op=OP_JAL, dec_class=jump, dec_imm=0xFFFFFFFC, rd=0.
- DEPTH=4, out_ready=0, continuous in_valid:
  - exactly 5 pushes are accepted, then in_ready=0 and q_count=4;
  - outputs stay frozen on instruction #1;
  - after releasing out_ready, instructions emerge in order, one per cycle.
- With q_count=3 and out_valid=1, assert flush together with in_valid=1 → next edge: q_count=0, out_valid=0, the pushed word never appears.
- Word 0x00000000 → dec_illegal=1, dec_op=OP_ILLEGAL, dec_class=0, out_valid=1.
- MUL x1,x2,x3 (0x023100B3):
  - with DEC_RV32M_EN → OP_MUL, class=reg, rs2=3;
  - without it → dec_illegal=1.
- Deassert hrstn with 2 entries queued and out_valid=1 → all outputs immediately 0 without a clock edge.
